// File: rtl/up_timer_pkg.sv
// Shared constants for the MM:SS up timer: FSM state encodings and digit moduli.
package up_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DIGITS        = 4;
    localparam int DIGIT_BITS    = 4;
    localparam int SEC_UNITS_MOD = 10;
    localparam int SEC_TENS_MOD  = 6;
    localparam int MIN_UNITS_MOD = 10;
    localparam int MIN_TENS_MOD  = 6;

    // Digit index 0..3 = S0, S1, M0, M1 (least significant first).
    function automatic int digit_modulo(input int idx);
        case (idx)
            0:       return SEC_UNITS_MOD;
            1:       return SEC_TENS_MOD;
            2:       return MIN_UNITS_MOD;
            default: return MIN_TENS_MOD;
        endcase
    endfunction

endpackage

// File: rtl/up_timer_up_cnt.sv
// UP_CNT: modulo-N up counter stage with clock enable and carry out, built for cascading.
module up_timer_up_cnt #(
    parameter int MODULO   = 10,
    parameter int BITS_NUM = 4
) (
    input  logic                CLK,
    input  logic                CLR_N,
    input  logic                CLR,
    input  logic                CE,
    output logic [BITS_NUM-1:0] Q,
    output logic                CEO
);

    localparam logic [BITS_NUM-1:0] LAST = BITS_NUM'(MODULO - 1);

    logic [BITS_NUM-1:0] q_reg;
    logic [BITS_NUM-1:0] q_next;
    logic                at_last;

    assign at_last = (q_reg == LAST);

    always_comb begin
        q_next = q_reg;
        if (CLR) begin
            q_next = '0;
        end else if (CE) begin
            q_next = at_last ? '0 : q_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign Q   = q_reg;
    assign CEO = CE & at_last;

endmodule

// File: rtl/up_timer.sv
// MM:SS up timer: four cascaded BCD stages gated by an IDLE/RUN/PAUSED/DONE controller.
module up_timer
    import up_timer_pkg::*;
#(
    parameter int WRAP      = 0,
    parameter bit START_RUN = 1'b0
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       TICK,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLEAR,
    output logic [3:0] S0,
    output logic [3:0] S1,
    output logic [3:0] M0,
    output logic [3:0] M1,
    output logic       RUNNING,
    output logic       DONE,
    output logic       CEO
);

    localparam bit HOLD_AT_MAX = (WRAP == 0);

    state_t state_reg;
    state_t state_next;
    logic   running_reg;
    logic   done_reg;

    logic [DIGIT_BITS-1:0] digit [DIGITS];
    logic [DIGITS:0]       carry;
    logic [DIGITS-1:0]     is_max;
    logic                  at_max;
    logic                  in_run;
    logic                  count_en;
    logic                  unused_wrap_carry;

    assign in_run = (state_reg == ST_RUN);
    assign at_max = &is_max;

    // In hold mode the last tick must not roll the cascade over to 00:00.
    assign count_en = TICK & in_run & ~STOP & ~CLEAR & ~(HOLD_AT_MAX & at_max);
    assign carry[0] = count_en;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            up_timer_up_cnt #(
                .MODULO   (digit_modulo(gi)),
                .BITS_NUM (DIGIT_BITS)
            ) u_cnt (
                .CLK   (CLK),
                .CLR_N (CLR_N),
                .CLR   (CLEAR),
                .CE    (carry[gi]),
                .Q     (digit[gi]),
                .CEO   (carry[gi+1])
            );
            assign is_max[gi] = (digit[gi] == DIGIT_BITS'(digit_modulo(gi) - 1));
        end
    endgenerate

    assign unused_wrap_carry = carry[DIGITS];

    always_comb begin
        state_next = state_reg;
        if (CLEAR) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   if (START && !STOP) state_next = ST_RUN;
                ST_RUN: begin
                    if (STOP) begin
                        state_next = ST_PAUSED;
                    end else if (TICK && at_max && HOLD_AT_MAX) begin
                        state_next = ST_DONE;
                    end
                end
                ST_PAUSED: if (START && !STOP) state_next = ST_RUN;
                default:   state_next = ST_DONE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_reg   <= START_RUN ? ST_RUN : ST_IDLE;
            running_reg <= START_RUN;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            running_reg <= (state_next == ST_RUN);
            done_reg    <= (state_next == ST_DONE);
        end
    end

    assign S0      = digit[0];
    assign S1      = digit[1];
    assign M0      = digit[2];
    assign M1      = digit[3];
    assign RUNNING = running_reg;
    assign DONE    = done_reg;
    // Gated by CLR_N so a START_RUN build cannot flag a carry while held in reset.
    assign CEO     = CLR_N & TICK & in_run & at_max;

endmodule

// File: tb/tb_up_timer.sv
// Directed bench for up_timer: one hold-mode (WRAP=0) and one wrap-mode (WRAP=1) instance on shared stimulus.
module tb_up_timer;

    logic CLK = 1'b0;
    logic CLR_N, TICK, START, STOP, CLEAR;
    logic [3:0] s0_h, s1_h, m0_h, m1_h, s0_w, s1_w, m0_w, m1_w;
    logic run_h, done_h, ceo_h, run_w, done_w, ceo_w;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    up_timer #(.WRAP(0), .START_RUN(1'b0)) dut_hold (
        .CLK(CLK), .CLR_N(CLR_N), .TICK(TICK), .START(START), .STOP(STOP), .CLEAR(CLEAR),
        .S0(s0_h), .S1(s1_h), .M0(m0_h), .M1(m1_h),
        .RUNNING(run_h), .DONE(done_h), .CEO(ceo_h)
    );

    up_timer #(.WRAP(1), .START_RUN(1'b0)) dut_wrap (
        .CLK(CLK), .CLR_N(CLR_N), .TICK(TICK), .START(START), .STOP(STOP), .CLEAR(CLEAR),
        .S0(s0_w), .S1(s1_w), .M0(m0_w), .M1(m1_w),
        .RUNNING(run_w), .DONE(done_w), .CEO(ceo_w)
    );

    function automatic logic [15:0] time_h();
        return {m1_h, m0_h, s1_h, s0_h};
    endfunction

    function automatic logic [15:0] time_w();
        return {m1_w, m0_w, s1_w, s0_w};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick_n(input int n);
        TICK = 1'b1;
        repeat (n) step();
        TICK = 1'b0;
    endtask

    initial begin
        CLR_N = 1'b0; TICK = 1'b1; START = 1'b0; STOP = 1'b0; CLEAR = 1'b0;

        // Reset state, with TICK held high to show CEO stays low
        #3;
        check("rst_digits_h", time_h(), 16'h0000);
        check("rst_digits_w", time_w(), 16'h0000);
        check("rst_running", {14'd0, run_h, run_w}, 16'h0000);
        check("rst_done", {14'd0, done_h, done_w}, 16'h0000);
        check("rst_ceo", {14'd0, ceo_h, ceo_w}, 16'h0000);
        step();
        TICK = 1'b0;
        step();
        CLR_N = 1'b1;
        step();
        check("idle_tick_ignored", time_h(), 16'h0000);

        // START pulse then 75 ticks -> 01:15
        START = 1'b1; step(); START = 1'b0;
        check("start_running", {14'd0, run_h, run_w}, 16'h0003);
        tick_n(75);
        check("t75_h", time_h(), 16'h0115);
        check("t75_w", time_w(), 16'h0115);
        check("t75_running", {15'd0, run_h}, 16'h0001);

        // CLEAR from RUN
        CLEAR = 1'b1; step(); CLEAR = 1'b0;
        check("clear_digits", time_h(), 16'h0000);
        check("clear_running", {15'd0, run_h}, 16'h0000);

        // START+TICK together from IDLE must not count
        START = 1'b1; TICK = 1'b1; step(); START = 1'b0;
        check("start_tick_digits", time_h(), 16'h0000);
        check("start_tick_running", {15'd0, run_h}, 16'h0001);
        step(); TICK = 1'b0;
        check("first_tick", time_h(), 16'h0001);

        // STOP+TICK at 00:09 pauses without counting
        tick_n(8);
        check("at_0009", time_h(), 16'h0009);
        STOP = 1'b1; TICK = 1'b1; step(); STOP = 1'b0; TICK = 1'b0;
        check("stop_tick_digits", time_h(), 16'h0009);
        check("stop_running", {15'd0, run_h}, 16'h0000);
        tick_n(3);
        check("paused_ticks", time_h(), 16'h0009);
        START = 1'b1; step(); START = 1'b0;
        tick_n(1);
        check("resume_0010", time_h(), 16'h0010);

        // Asynchronous reset at 12:34, between edges
        CLEAR = 1'b1; step(); CLEAR = 1'b0;
        START = 1'b1; step(); START = 1'b0;
        tick_n(754);
        check("at_1234", time_w(), 16'h1234);
        #2 CLR_N = 1'b0;
        #1;
        check("async_rst_digits", time_h(), 16'h0000);
        check("async_rst_running", {14'd0, run_h, run_w}, 16'h0000);
        #1 CLR_N = 1'b1;
        step();
        check("post_rst_digits", time_w(), 16'h0000);
        CLEAR = 1'b1; START = 1'b1; step(); CLEAR = 1'b0; START = 1'b0;
        check("clear_beats_start", {14'd0, run_h, run_w}, 16'h0000);

        // Count to 59:58, then the two critical ticks
        START = 1'b1; step(); START = 1'b0;
        tick_n(3598);
        check("at_5958_h", time_h(), 16'h5958);
        check("at_5958_w", time_w(), 16'h5958);
        TICK = 1'b1;
        #1;
        check("ceo_low_5958", {14'd0, ceo_h, ceo_w}, 16'h0000);
        step();
        check("at_5959_h", time_h(), 16'h5959);
        check("at_5959_w", time_w(), 16'h5959);
        check("ceo_high_5959", {14'd0, ceo_h, ceo_w}, 16'h0003);
        step();
        check("hold_digits", time_h(), 16'h5959);
        check("hold_done", {15'd0, done_h}, 16'h0001);
        check("hold_running", {15'd0, run_h}, 16'h0000);
        check("wrap_digits", time_w(), 16'h0000);
        check("wrap_state", {14'd0, run_w, done_w}, 16'h0002);
        check("ceo_after", {14'd0, ceo_h, ceo_w}, 16'h0000);
        START = 1'b1; step(); START = 1'b0; TICK = 1'b0;
        check("done_frozen", time_h(), 16'h5959);
        check("done_held", {14'd0, done_h, run_h}, 16'h0002);
        check("wrap_continues", time_w(), 16'h0001);

        // Only CLEAR leaves DONE
        CLEAR = 1'b1; step(); CLEAR = 1'b0;
        check("done_clear_digits", time_h(), 16'h0000);
        check("done_clear_flag", {15'd0, done_h}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_timer.md
UP_TIMER -- requirements
Module: up_timer

Interface
REQ-001 Parameter WRAP, default 0: 0 = stop and hold at 59:59; 1 = roll over to 00:00 and continue counting.
REQ-002 Parameter START_RUN, default 0: 1 = the state after reset is RUN instead of IDLE.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 CLR_N  in  1  asynchronous, active-low reset.
REQ-005 TICK  in  1  one-cycle 1 Hz count-enable strobe.
REQ-006 START  in  1  level sampled each cycle; requests counting.
REQ-007 STOP  in  1  level sampled each cycle; requests pause.
REQ-008 CLEAR  in  1  synchronous request to zero all digits and go to IDLE.
REQ-009 S0  out  4  BCD seconds units, range 0-9.
REQ-010 S1  out  4  BCD seconds tens, range 0-5.
REQ-011 M0  out  4  BCD minutes units, range 0-9.
REQ-012 M1  out  4  BCD minutes tens, range 0-5.
REQ-013 RUNNING  out  1  high while in state RUN.
REQ-014 DONE  out  1  high while in state DONE.
REQ-015 CEO  out  1  combinational carry out: TICK & RUN & digits=59:59.

Function
REQ-016 FSM states SHALL be IDLE, RUN, PAUSED and DONE.
REQ-017 IDLE: START with no STOP and no CLEAR goes to RUN; all other input combinations stay in IDLE.
REQ-018 RUN: STOP goes to PAUSED; when WRAP=0, a TICK at 59:59 goes to DONE.
REQ-019 PAUSED: START with no STOP goes to RUN; otherwise stay in PAUSED.
REQ-020 DONE: only CLEAR or reset leaves DONE; START and STOP are ignored.
REQ-021 From any state, CLEAR SHALL go to IDLE with digits 00:00 on the next edge, overriding START, STOP and TICK.
REQ-022 Priority SHALL be CLEAR > STOP > START > TICK.
REQ-023 Digits SHALL advance only on TICK in RUN when neither STOP nor CLEAR is active; TICK in any other state is ignored.
REQ-024 A TICK in the same cycle as the IDLE/PAUSED->RUN transition SHALL NOT count.
REQ-025 Latency: digits update on the edge that samples TICK, so new values are visible in the next cycle.
REQ-026 Carry chain: S0 9->0 carries into S1; S1 5->0 carries into M0; M0 9->0 carries into M1; M1 5->0 produces CEO.
REQ-027 WRAP=1: a TICK at 59:59 SHALL give 00:00 with CEO high in that TICK cycle; state stays RUN.
REQ-028 WRAP=0: a TICK at 59:59 SHALL hold 59:59, enter DONE and assert CEO for that cycle; digits then freeze.
REQ-029 Digits SHALL never take non-BCD or out-of-range values.

Reset
REQ-030 CLR_N low SHALL immediately force digits 00:00, RUNNING=0, DONE=0, and state IDLE (or RUN if START_RUN=1), regardless of CLK.
REQ-031 CEO SHALL be 0 throughout reset.
REQ-032 Counting SHALL resume only on the first TICK sampled after CLR_N has been high for at least one edge.
REQ-033 Reset asserted mid-count SHALL discard the count; no partial carry survives.

Structure
REQ-034 State encodings and the digit moduli (10, 6) SHALL live in the shared project constants package/include.
REQ-035 One sub-module UP_CNT (parameters MODULO, BITS_NUM; ports CLK, CLR_N, CLR, CE, Q, CEO) SHALL be instantiated four times as a CE/CEO cascade.
REQ-036 UP_CNT counts up from 0 and wraps at MODULO-1; its CEO = CE & (Q==MODULO-1).
REQ-037 The FSM, hold logic and DONE detection SHALL reside in up_timer.

Verification
REQ-038 Reset, START pulse, then 75 TICKs -> digits 01:15, RUNNING=1.
REQ-039 WRAP=1: preload to 59:58 via ticks, then 2 TICKs -> 59:59 then 00:00; CEO high exactly during the second TICK.
REQ-040 WRAP=0: reach 59:59, then 1 TICK -> holds 59:59, DONE=1, CEO one cycle; a further START and TICK change nothing.
REQ-041 START+TICK in the same cycle from IDLE -> 00:00 unchanged; next TICK -> 00:01.
REQ-042 STOP+TICK at 00:09 -> PAUSED, digits stay 00:09; START, then TICK -> 00:10.
REQ-043 CLR_N pulsed low between clock edges at 12:34 -> 00:00 and IDLE immediately; CLEAR+START in the same cycle -> IDLE.
